// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the 7-segment readback path.
//   Glyphs are active-high in a..g order (bit 6 = a, bit 0 = g).
//   dec_t is the decoded result of one digit pattern.
package seg_pkg;

    localparam logic [6:0] GLYPH_0  = 7'h7E;
    localparam logic [6:0] GLYPH_1  = 7'h30;
    localparam logic [6:0] GLYPH_2  = 7'h6D;
    localparam logic [6:0] GLYPH_3  = 7'h79;
    localparam logic [6:0] GLYPH_4  = 7'h33;
    localparam logic [6:0] GLYPH_5  = 7'h5B;
    localparam logic [6:0] GLYPH_6  = 7'h5F;
    localparam logic [6:0] GLYPH_6A = 7'h1F;   // 6 without segment a
    localparam logic [6:0] GLYPH_7  = 7'h70;
    localparam logic [6:0] GLYPH_8  = 7'h7F;
    localparam logic [6:0] GLYPH_9  = 7'h7B;
    localparam logic [6:0] GLYPH_9A = 7'h73;   // 9 without segment d
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [3:0] NIB_BAD   = 4'hF;

    typedef struct packed {
        logic [3:0] nib;
        logic       blank;
        logic       bad;
    } dec_t;

    // Frame assembly view derived from the capture mask.
    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_COLLECT,
        ST_DONE
    } scan_st_e;

    function automatic dec_t mk_dec(input logic [3:0] n, input logic b, input logic x);
        dec_t d;
        d.nib   = n;
        d.blank = b;
        d.bad   = x;
        return d;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: scanned display lines in, reconstructed frame out.
//   seg/an_n       : sampled display bus (driven by master)
//   digits..bad    : last complete frame (driven by slave)
//   frame_valid / frame_changed : one-cycle strobes; scan_lost : level
interface seg_scan_decoder_if;
    logic [6:0]  seg;
    logic [3:0]  an_n;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  bad;
    logic        frame_valid;
    logic        frame_changed;
    logic        scan_lost;

    modport master (
        output seg, an_n,
        input  digits, blank, bad, frame_valid, frame_changed, scan_lost
    );

    modport slave (
        input  seg, an_n,
        output digits, blank, bad, frame_valid, frame_changed, scan_lost
    );
endinterface

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: combinational active-high segment pattern -> {nibble, blank, bad}.
//   i_pat : a..g, bit 6 = a
//   o_dec : nibble 0-9, blank (all-off, nibble 0), bad (nibble F)
module seg7_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] i_pat,
    output dec_t       o_dec
);

    always_comb begin
        o_dec = mk_dec(NIB_BAD, 1'b0, 1'b1);
        case (i_pat)
            GLYPH_0:             o_dec = mk_dec(4'd0, 1'b0, 1'b0);
            GLYPH_1:             o_dec = mk_dec(4'd1, 1'b0, 1'b0);
            GLYPH_2:             o_dec = mk_dec(4'd2, 1'b0, 1'b0);
            GLYPH_3:             o_dec = mk_dec(4'd3, 1'b0, 1'b0);
            GLYPH_4:             o_dec = mk_dec(4'd4, 1'b0, 1'b0);
            GLYPH_5:             o_dec = mk_dec(4'd5, 1'b0, 1'b0);
            GLYPH_6, GLYPH_6A:   o_dec = mk_dec(4'd6, 1'b0, 1'b0);
            GLYPH_7:             o_dec = mk_dec(4'd7, 1'b0, 1'b0);
            GLYPH_8:             o_dec = mk_dec(4'd8, 1'b0, 1'b0);
            GLYPH_9, GLYPH_9A:   o_dec = mk_dec(4'd9, 1'b0, 1'b0);
            SEG_BLANK:           o_dec = mk_dec(4'd0, 1'b1, 1'b0);
            default:             ;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples the multiplexed 7-seg bus and rebuilds the
// four displayed digits as BCD.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave modport -- seg/an_n in; digits, blank, bad,
//                frame_valid, frame_changed, scan_lost out
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT        = 250000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_decoder_if.slave  bus
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT);

    logic [6:0]       r_seg_s1, r_seg_s2, r_seg_prev;
    logic [3:0]       r_an_s1, r_an_s2, r_an_prev;
    logic [SW-1:0]    r_stab;
    logic [WW-1:0]    r_wd;
    logic [3:0]       r_mask;
    logic [3:0][3:0]  r_slot_nib;
    logic [3:0]       r_slot_blank, r_slot_bad;
    logic [15:0]      r_digits;
    logic [3:0]       r_blank, r_bad;
    logic             r_fv, r_fc, r_lost;
    logic             r_first;   // no frame delivered since reset

    logic             w_qual, w_hold, w_cap, w_done, w_to, w_changed;
    logic [6:0]       w_pat;
    logic [1:0]       w_idx;
    logic [3:0]       w_capbit;
    dec_t             w_dec;
    scan_st_e         w_state;

    seg7_to_bcd u_dec (.i_pat(w_pat), .o_dec(w_dec));

    always_comb begin
        w_qual   = ($countones(~r_an_s2) == 1);
        w_hold   = w_qual && ({r_an_s2, r_seg_s2} == {r_an_prev, r_seg_prev});
        // Fires on the edge where the counter lands on its final value.
        w_cap    = w_hold && (r_stab == STAB_MAX - 1'b1);
        w_pat    = SEG_ACTIVE_LOW ? ~r_seg_s2 : r_seg_s2;
        w_capbit = w_cap ? ~r_an_s2 : 4'b0000;
        w_idx    = 2'd0;
        for (int i = 0; i < 4; i++)
            if (!r_an_s2[i]) w_idx = 2'(i);
        w_state  = ST_COLLECT;
        if (r_mask == 4'b0000)      w_state = ST_SEARCH;
        else if (r_mask == 4'b1111) w_state = ST_DONE;
        w_done   = (w_state == ST_DONE);
        w_to     = !w_cap && (r_wd == WD_MAX - 1'b1);
        w_changed = r_first ||
                    ({r_slot_nib, r_slot_blank, r_slot_bad} != {r_digits, r_blank, r_bad});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_s1   <= '0;
            r_seg_s2   <= '0;
            r_seg_prev <= '0;
            r_an_s1    <= 4'hF;
            r_an_s2    <= 4'hF;
            r_an_prev  <= 4'hF;
            r_stab     <= '0;
        end else begin
            r_seg_s1   <= bus.seg;
            r_seg_s2   <= r_seg_s1;
            r_an_s1    <= bus.an_n;
            r_an_s2    <= r_an_s1;
            r_seg_prev <= r_seg_s2;
            r_an_prev  <= r_an_s2;
            if (!w_hold)
                r_stab <= '0;
            else if (r_stab != STAB_MAX)
                r_stab <= r_stab + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask       <= '0;
            r_slot_nib   <= '0;
            r_slot_blank <= '0;
            r_slot_bad   <= '0;
            r_digits     <= 16'h0000;
            r_blank      <= 4'hF;
            r_bad        <= 4'h0;
            r_fv         <= 1'b0;
            r_fc         <= 1'b0;
            r_first      <= 1'b1;
        end else begin
            // A capture on the clearing edge seeds the next frame.
            r_mask <= ((w_done || w_to) ? 4'b0000 : r_mask) | w_capbit;
            if (w_cap) begin
                r_slot_nib[w_idx]   <= w_dec.nib;
                r_slot_blank[w_idx] <= w_dec.blank;
                r_slot_bad[w_idx]   <= w_dec.bad;
            end
            r_fv <= w_done;
            r_fc <= w_done && w_changed;
            if (w_done) begin
                r_digits <= r_slot_nib;
                r_blank  <= r_slot_blank;
                r_bad    <= r_slot_bad;
                r_first  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd   <= '0;
            r_lost <= 1'b0;
        end else if (w_cap) begin
            r_wd   <= '0;
            r_lost <= 1'b0;
        end else if (r_wd != WD_MAX) begin
            r_wd   <= r_wd + 1'b1;
            r_lost <= (r_wd == WD_MAX - 1'b1);
        end
    end

    assign bus.digits        = r_digits;
    assign bus.blank         = r_blank;
    assign bus.bad           = r_bad;
    assign bus.frame_valid   = r_fv;
    assign bus.frame_changed = r_fc;
    assign bus.scan_lost     = r_lost;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scans plus random dwells, checked
// against a dwell-level model of what the display is showing.
module tb_seg_scan_decoder;

    localparam int S  = 16;
    localparam int TO = 600;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_decoder_if bus();

    seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT(TO), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Legal glyphs (active-high, a..g) and their digit values.
    logic [6:0] GL [12] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                            7'h5F, 7'h1F, 7'h70, 7'h7F, 7'h7B, 7'h73};
    logic [3:0] NB [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                            4'd6, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9};

    typedef struct {
        logic [15:0] d;
        logic [3:0]  b;
        logic [3:0]  x;
        logic        c;
    } frm_t;
    frm_t q[$];

    logic [3:0]  m_nib [4];
    logic [3:0]  m_blk, m_bad, m_mask;
    logic [15:0] m_ld;
    logic [3:0]  m_lb, m_lx;
    logic        m_first;
    int          since_cap;

    function automatic void dec(input logic [6:0] p, output logic [3:0] n,
                                output logic b, output logic x);
        n = 4'hF; b = 1'b0; x = 1'b1;
        if (p == 7'h00) begin n = 4'd0; b = 1'b1; x = 1'b0; end
        for (int i = 0; i < 12; i++)
            if (p == GL[i]) begin n = NB[i]; x = 1'b0; end
    endfunction

    task automatic m_reset();
        m_mask = 4'h0; m_blk = 4'h0; m_bad = 4'h0;
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
        m_ld = 16'h0000; m_lb = 4'hF; m_lx = 4'h0;
        m_first = 1'b1; since_cap = 0;
    endtask

    // One dwell of n cycles on anode a: captured if held at least S cycles.
    task automatic m_step(input int a, input logic [6:0] p, input int n);
        frm_t f;
        logic [3:0] nn; logic bb, xx;
        int pre;
        pre = (n >= S) ? S : n;
        if (since_cap + pre >= TO) m_mask = 4'h0;
        if (n >= S) begin
            dec(p, nn, bb, xx);
            m_nib[a] = nn; m_blk[a] = bb; m_bad[a] = xx;
            m_mask[a] = 1'b1;
            since_cap = n - S;
            if (m_mask == 4'hF) begin
                f.d = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                f.b = m_blk; f.x = m_bad;
                f.c = m_first || ({f.d, f.b, f.x} != {m_ld, m_lb, m_lx});
                q.push_back(f);
                m_ld = f.d; m_lb = f.b; m_lx = f.x; m_first = 1'b0;
                m_mask = 4'h0;
            end
        end else begin
            since_cap += n;
        end
        if (since_cap >= TO) m_mask = 4'h0;
    endtask

    task automatic dwell(input int a, input logic [6:0] p, input int n);
        m_step(a, p, n);
        bus.an_n = ~(4'b0001 << a);
        bus.seg  = ~p;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input logic [3:0] an, input int n);
        since_cap += n;
        if (since_cap >= TO) m_mask = 4'h0;
        bus.an_n = an;
        bus.seg  = 7'($urandom);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        frm_t f;
        if (rst_n && bus.frame_valid) begin
            if (q.size() == 0) begin
                chk("fv_unexpected", 32'(bus.frame_valid), 32'd0);
            end else begin
                f = q.pop_front();
                chk("fr_digits",  32'(bus.digits),        32'(f.d));
                chk("fr_blank",   32'(bus.blank),         32'(f.b));
                chk("fr_bad",     32'(bus.bad),           32'(f.x));
                chk("fr_changed", 32'(bus.frame_changed), 32'(f.c));
                chk("fr_lost",    32'(bus.scan_lost),     32'd0);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_digits"}, 32'(bus.digits),        32'h0000);
        chk({tag, "_blank"},  32'(bus.blank),         32'hF);
        chk({tag, "_bad"},    32'(bus.bad),           32'h0);
        chk({tag, "_fv"},     32'(bus.frame_valid),   32'd0);
        chk({tag, "_fc"},     32'(bus.frame_changed), 32'd0);
        chk({tag, "_lost"},   32'(bus.scan_lost),     32'd0);
    endtask

    initial begin
        int pa, a, n, k;
        logic [6:0] p;
        m_reset();
        bus.an_n = 4'hF;
        bus.seg  = 7'h7F;
        repeat (5) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // "1259"
        dwell(3, 7'h30, 100); dwell(2, 7'h6D, 100); dwell(1, 7'h5B, 100); dwell(0, 7'h7B, 100);
        chk("s1259_digits", 32'(bus.digits), 32'h1259);
        chk("s1259_lost",   32'(bus.scan_lost), 32'd0);
        // same again, then "1300"
        dwell(3, 7'h30, 100); dwell(2, 7'h6D, 100); dwell(1, 7'h5B, 100); dwell(0, 7'h7B, 100);
        dwell(3, 7'h30, 100); dwell(2, 7'h79, 100); dwell(1, 7'h7E, 100); dwell(0, 7'h7E, 100);
        chk("s1300_digits", 32'(bus.digits), 32'h1300);

        // partial frame, then dwells one cycle too short, then watchdog
        dwell(3, 7'h5B, 100); dwell(2, 7'h5B, 100);
        for (int r = 0; r < 4; r++)
            for (int i = 3; i >= 0; i--) dwell(i, 7'h7F, S - 1);
        chk("short_lost0", 32'(bus.scan_lost), 32'd0);
        idle(4'hF, 400);
        chk("to_lost1",  32'(bus.scan_lost), 32'd1);
        chk("to_digits", 32'(bus.digits),    32'h1300);

        // blank and bad digits; stale partial frame must have been dropped
        dwell(1, 7'h00, 100); dwell(0, 7'h41, 100);
        chk("recap_lost0", 32'(bus.scan_lost), 32'd0);
        dwell(3, 7'h33, 100); dwell(2, 7'h70, 100);
        chk("bb_digits", 32'(bus.digits), 32'h470F);
        chk("bb_blank",  32'(bus.blank),  32'b0010);
        chk("bb_bad",    32'(bus.bad),    32'b0001);

        // overlapping anodes, then alternate 6/9 glyphs
        idle(4'b1100, 50);
        dwell(3, 7'h1F, 100); dwell(2, 7'h73, 100); dwell(1, 7'h5F, 100); dwell(0, 7'h7B, 100);
        chk("alt_digits", 32'(bus.digits), 32'h6969);

        // reset mid-frame, then an all-blank frame (equals reset values)
        dwell(3, 7'h5B, 100); dwell(2, 7'h5B, 100);
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        chk_reset_vals("mid_rst");
        rst_n = 1'b1;
        for (int i = 3; i >= 0; i--) dwell(i, 7'h00, 100);
        chk("blank_frame_blank", 32'(bus.blank), 32'hF);

        // random dwells
        pa = 0;
        for (int t = 0; t < 200; t++) begin
            do a = $urandom_range(3, 0); while (a == pa);
            pa = a;
            k = $urandom_range(9, 0);
            if (k < 7)       p = GL[$urandom_range(11, 0)];
            else if (k == 7) p = 7'h00;
            else             p = 7'($urandom);
            k = $urandom_range(7, 0);
            if (k == 0)      n = S - 1;
            else if (k == 1) n = S;
            else             n = $urandom_range(100, S + 1);
            if (since_cap > 300) begin
                n = 100;
                p = GL[$urandom_range(11, 0)];
            end
            dwell(a, p, n);
        end

        idle(4'hF, 30);
        chk("q_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
